line_buffer_multitap: RTL

//  Multi-line delay buffer for streaming raster video. Stores NUM_LINES previous lines in

---
 rtl/line_buffer_multitap.sv | 93 +++++++++
 1 files changed

// File: rtl/line_buffer_multitap.sv
// rtl/line_buffer_multitap.sv - multi-line ring buffer emitting a vertical pixel column per input pixel
module line_buffer_multitap #(
    parameter int WIDTH     = 8,
    parameter int IMG_WIDTH = 1280,
    parameter int NUM_LINES = 2,
    parameter int ADDR_W    = 11
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sof,
    input  logic                             valid_in,
    input  logic [WIDTH-1:0]                 din,
    output logic [WIDTH*(NUM_LINES+1)-1:0]   taps,
    output logic                             valid_out,
    output logic [ADDR_W-1:0]                col_out,
    output logic                             eol_out
);

    localparam int TW = WIDTH * (NUM_LINES + 1);
    localparam int RW = $clog2(NUM_LINES + 1);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]     FULL_ROWS = RW'(NUM_LINES);

    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] col_eff;
    logic [RW-1:0]     rows;
    logic [RW-1:0]     rows_eff;
    logic [RW-1:0]     rows_next;
    logic              at_last;
    logic [TW-1:0]     taps_next;

    // Line k holds the pixel written k+1 lines ago at each column; never cleared,
    // stale contents are hidden by valid_out until every line is refilled.
    logic [WIDTH-1:0] mem [NUM_LINES][IMG_WIDTH];
    logic [WIDTH-1:0] rd  [NUM_LINES];

    // sof restarts the frame on this very pixel, overriding the running counters
    always_comb begin
        col_eff  = sof ? '0 : col;
        rows_eff = sof ? '0 : rows;
        at_last  = (col_eff == LAST_COL);
        if (at_last && (rows_eff != FULL_ROWS)) begin
            rows_next = rows_eff + RW'(1);
        end else begin
            rows_next = rows_eff;
        end
    end

    // Asynchronous read of every stored line at the current column (old data, pre-write)
    always_comb begin
        for (int k = 0; k < NUM_LINES; k++) begin
            rd[k] = mem[k][col_eff];
        end
        taps_next = '0;
        taps_next[WIDTH-1:0] = din;
        for (int k = 1; k <= NUM_LINES; k++) begin
            taps_next[k*WIDTH +: WIDTH] = rd[k-1];
        end
    end

    // Shift the column down one line: new pixel into line 0, each line into the next
    always_ff @(posedge clk) begin
        if (valid_in && rst_n) begin
            mem[0][col_eff] <= din;
            for (int k = 1; k < NUM_LINES; k++) begin
                mem[k][col_eff] <= rd[k-1];
            end
        end
    end

    // Position counters and registered output column
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col       <= '0;
            rows      <= '0;
            taps      <= '0;
            valid_out <= 1'b0;
            col_out   <= '0;
            eol_out   <= 1'b0;
        end else if (valid_in) begin
            col       <= at_last ? '0 : col_eff + ADDR_W'(1);
            rows      <= rows_next;
            taps      <= taps_next;
            valid_out <= (rows_eff >= FULL_ROWS);
            col_out   <= col_eff;
            eol_out   <= at_last;
        end else begin
            valid_out <= 1'b0;
            eol_out   <= 1'b0;
        end
    end

endmodule
